// File: rtl/reg_file_sb.sv
// 8 x 16-bit register file with a pending-write scoreboard that stalls issue on RAW/full hazards.
// Optional feature macro: RF_BYPASS_EN (write-back forwarded to rf_out and hazard check in the wb cycle).
module reg_file_sb #(
    parameter int unsigned PEND_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  ir,
    input  logic         iss_valid,
    output logic         iss_go,
    output logic         stall,
    input  logic         wb_we,
    input  logic [2:0]   wb_addr,
    input  logic [15:0]  wb_data,
    output logic [127:0] rf_out,
    output logic [7:0]   pend,
    output logic         sb_err
);

    localparam int unsigned NREG = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]     regs_q [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];
    logic [PEND_W-1:0] eff_cnt[NREG];
    logic [NREG-1:0]   pend_q;
    logic              sb_err_q;
    logic              sb_err_d;
    logic [NREG-1:0]   inc_v;
    logic [NREG-1:0]   dec_v;
    logic [AW-1:0]     ra;
    logic [AW-1:0]     rb;
    logic [AW-1:0]     dst;
    logic              raw_a;
    logic              raw_b;
    logic              full;

    // Hazard detection; a source retiring this cycle is forgiven only with bypass.
    always_comb begin
        ra  = ir[13:11];
        rb  = ir[10:8];
        dst = ir[13:11];
        for (int unsigned i = 0; i < NREG; i++) begin
            eff_cnt[i] = cnt_q[i];
        end
`ifdef RF_BYPASS_EN
        if (wb_we && (cnt_q[wb_addr] != '0)) begin
            eff_cnt[wb_addr] = cnt_q[wb_addr] - PEND_W'(1);
        end
`endif
        raw_a  = (eff_cnt[ra] != '0);
        raw_b  = (eff_cnt[rb] != '0);
        full   = (cnt_q[dst] == CNT_MAX) && !(wb_we && (wb_addr == dst));
        stall  = rst_n && iss_valid && (raw_a || raw_b || full);
        iss_go = rst_n && iss_valid && !(raw_a || raw_b || full);
    end

    // Per-register pending counters; matched inc/dec cancel, dec at zero flags an error.
    always_comb begin
        sb_err_d = sb_err_q;
        inc_v    = '0;
        dec_v    = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            inc_v[i] = iss_go && (dst == AW'(i));
            dec_v[i] = wb_we && (wb_addr == AW'(i));
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + PEND_W'(1);
            end else if (dec_v[i] && !inc_v[i]) begin
                if (cnt_q[i] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - PEND_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            pend_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            if (wb_we) begin
                regs_q[wb_addr] <= wb_data;
            end
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i]  <= cnt_d[i];
                pend_q[i] <= (cnt_d[i] != '0);
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Flat register image, held at zero while reset is asserted.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            rf_out[i*DW +: DW] = regs_q[i];
        end
`ifdef RF_BYPASS_EN
        if (wb_we) begin
            rf_out[{wb_addr, 4'b0000} +: DW] = wb_data;
        end
`endif
        if (!rst_n) begin
            rf_out = '0;
        end
    end

    assign pend   = pend_q;
    assign sb_err = sb_err_q;

endmodule
